// File: rtl/jtcop_arb_pkg.sv
// rtl/jtcop_arb_pkg.sv - shared types, widths and priority helper for the SDRAM bank arbiter
package jtcop_arb_pkg;

    localparam int SDRAM_AW = 22;
    localparam int DW       = 16;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_DATA
    } arb_state_t;

    // Index of the lowest set bit; 0 when the vector is empty (callers qualify with |vec).
    function automatic logic [2:0] find_low(input logic [7:0] vec);
        find_low = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) find_low = 3'(i);
        end
    endfunction

endpackage

// File: rtl/jtcop_sdram_arb_if.sv
// rtl/jtcop_sdram_arb_if.sv - SDRAM bank port between the arbiter (master) and the controller (slave)
interface jtcop_sdram_arb_if;
    import jtcop_arb_pkg::*;

    logic [SDRAM_AW-1:0] sdram_addr;
    logic                sdram_rd;
    logic                sdram_wr;
    logic                sdram_ack;
    logic                data_dst;
    logic                data_rdy;
    logic [DW-1:0]       data_read;
    logic [DW-1:0]       data_write;
    logic [1:0]          sdram_wrmask;

    modport master (
        output sdram_addr, sdram_rd, sdram_wr, data_write, sdram_wrmask,
        input  sdram_ack, data_dst, data_rdy, data_read
    );

    modport slave (
        input  sdram_addr, sdram_rd, sdram_wr, data_write, sdram_wrmask,
        output sdram_ack, data_dst, data_rdy, data_read
    );

endinterface

// File: rtl/jtcop_arb_prio.sv
// rtl/jtcop_arb_prio.sv - combinational slot selector: starved slots first, then fixed or round-robin order
module jtcop_arb_prio
    import jtcop_arb_pkg::*;
#(
    parameter int SLOTS = 5,
    parameter int RR    = 0,
    parameter int IW    = 3
) (
    input  logic [SLOTS-1:0] pending,
    input  logic [IW-1:0]    ptr,
    input  logic [SLOTS-1:0] starve,
    output logic [SLOTS-1:0] gnt_oh,
    output logic [IW-1:0]    gnt_idx,
    output logic             gnt_any
);

    logic [7:0] pend8;
    logic [7:0] starve8;
    logic [7:0] above8;
    logic [2:0] idx3;

    always_comb begin
        pend8   = 8'(pending);
        starve8 = 8'(starve);
        // Round-robin: first look at or above the pointer, then wrap to the bottom.
        above8  = pend8 & (8'hFF << ptr);
        if (|starve8) begin
            idx3 = find_low(starve8);
        end else if (RR != 0 && |above8) begin
            idx3 = find_low(above8);
        end else begin
            idx3 = find_low(pend8);
        end
        gnt_any = |pending;
        gnt_idx = IW'(idx3);
        gnt_oh  = gnt_any ? (SLOTS'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/jtcop_sdram_arb.sv
// rtl/jtcop_sdram_arb.sv - N-slot SDRAM bank client with per-slot offset and one-word read cache
// Optional starvation override: define JTCOP_SDRAM_ARB_STARVE_EN.
module jtcop_sdram_arb
    import jtcop_arb_pkg::*;
#(
    parameter int SLOTS   = 5,
    parameter int AW      = 15,
    parameter int RR      = 0,
    parameter int MAXWAIT = 63
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SLOTS-1:0]        slot_cs,
    input  logic [SLOTS*AW-1:0]     slot_addr,
    input  logic [SLOTS*SDRAM_AW-1:0] slot_offset,
    input  logic [SLOTS-1:0]        slot_wen,
    input  logic [SLOTS*DW-1:0]     slot_din,
    input  logic [SLOTS*2-1:0]      slot_wrmask,
    output logic [SLOTS*DW-1:0]     slot_dout,
    output logic [SLOTS-1:0]        slot_ok,
    jtcop_sdram_arb_if.master       sdram
);

    localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    arb_state_t          state, state_nx;
    logic [IW-1:0]       win, win_nx, rr_ptr, ptr_nx;
    logic [AW-1:0]       lat_addr, lat_addr_nx;
    logic                lat_wen, lat_wen_nx;
    logic                rd_nx, wr_nx;
    logic [SDRAM_AW-1:0] addr_nx;
    logic [DW-1:0]       dw_nx;
    logic [1:0]          mask_nx;
    logic                grant, fill;

    logic [SLOTS-1:0]    cache_vld, wdone;
    logic [AW-1:0]       cache_addr [SLOTS];
    logic [SDRAM_AW-1:0] cache_full [SLOTS];
    logic [DW-1:0]       cache_data [SLOTS];
    logic [AW-1:0]       wdone_addr [SLOTS];
    logic [SDRAM_AW-1:0] full_addr  [SLOTS];

    logic [SLOTS-1:0]    hit, done_eff, pending, inval, starve, gnt_oh, ok_nx;
    logic [IW-1:0]       gnt_idx;
    logic                gnt_any;

    jtcop_arb_prio #(.SLOTS(SLOTS), .RR(RR), .IW(IW)) u_prio (
        .pending (pending),
        .ptr     (rr_ptr),
        .starve  (starve),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            logic own_fill, match;
            full_addr[i] = slot_offset[i*SDRAM_AW +: SDRAM_AW] + SDRAM_AW'(slot_addr[i*AW +: AW]);
            hit[i]       = cache_vld[i] && (cache_addr[i] == slot_addr[i*AW +: AW]);
            done_eff[i]  = wdone[i] && (wdone_addr[i] == slot_addr[i*AW +: AW]);
            pending[i]   = slot_cs[i] && (slot_wen[i] ? !done_eff[i] : !hit[i]);
            inval[i]     = fill && lat_wen && cache_vld[i] && (cache_full[i] == sdram.sdram_addr);
            own_fill     = fill && (win == IW'(i));
            match        = lat_addr == slot_addr[i*AW +: AW];
            // A cache being overwritten or invalidated this cycle must not report a stale hit.
            if (slot_wen[i]) begin
                ok_nx[i] = slot_cs[i] && (done_eff[i] || (own_fill && lat_wen && match));
            end else begin
                ok_nx[i] = slot_cs[i] &&
                           ((hit[i] && !inval[i] && !(own_fill && !lat_wen)) ||
                            (own_fill && !lat_wen && match));
            end
            slot_dout[i*DW +: DW] = cache_data[i];
        end
    end

    always_comb begin
        state_nx    = state;
        win_nx      = win;
        ptr_nx      = rr_ptr;
        lat_addr_nx = lat_addr;
        lat_wen_nx  = lat_wen;
        rd_nx       = sdram.sdram_rd;
        wr_nx       = sdram.sdram_wr;
        addr_nx     = sdram.sdram_addr;
        dw_nx       = sdram.data_write;
        mask_nx     = sdram.sdram_wrmask;
        grant       = 1'b0;
        fill        = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    grant       = 1'b1;
                    win_nx      = gnt_idx;
                    ptr_nx      = (gnt_idx == IW'(SLOTS-1)) ? '0 : gnt_idx + IW'(1);
                    lat_addr_nx = slot_addr[int'(gnt_idx)*AW +: AW];
                    lat_wen_nx  = slot_wen[gnt_idx];
                    addr_nx     = full_addr[gnt_idx];
                    dw_nx       = slot_din[int'(gnt_idx)*DW +: DW];
                    mask_nx     = slot_wrmask[int'(gnt_idx)*2 +: 2];
                    rd_nx       = !slot_wen[gnt_idx];
                    wr_nx       = slot_wen[gnt_idx];
                    state_nx    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (sdram.sdram_ack) begin
                    rd_nx    = 1'b0;
                    wr_nx    = 1'b0;
                    state_nx = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (sdram.data_rdy) begin
                    fill     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            win                <= '0;
            rr_ptr             <= '0;
            lat_addr           <= '0;
            lat_wen            <= 1'b0;
            sdram.sdram_rd     <= 1'b0;
            sdram.sdram_wr     <= 1'b0;
            sdram.sdram_addr   <= '0;
            sdram.data_write   <= '0;
            sdram.sdram_wrmask <= '0;
        end else begin
            state              <= state_nx;
            win                <= win_nx;
            rr_ptr             <= ptr_nx;
            lat_addr           <= lat_addr_nx;
            lat_wen            <= lat_wen_nx;
            sdram.sdram_rd     <= rd_nx;
            sdram.sdram_wr     <= wr_nx;
            sdram.sdram_addr   <= addr_nx;
            sdram.data_write   <= dw_nx;
            sdram.sdram_wrmask <= mask_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_ok   <= '0;
            cache_vld <= '0;
            wdone     <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                cache_addr[i] <= '0;
                cache_full[i] <= '0;
                cache_data[i] <= '0;
                wdone_addr[i] <= '0;
            end
        end else begin
            slot_ok <= ok_nx;
            for (int i = 0; i < SLOTS; i++) begin
                if (fill && !lat_wen && win == IW'(i)) begin
                    cache_vld[i]  <= 1'b1;
                    cache_addr[i] <= lat_addr;
                    cache_full[i] <= sdram.sdram_addr;
                    cache_data[i] <= sdram.data_read;
                end else if (inval[i]) begin
                    cache_vld[i]  <= 1'b0;
                end
                if (fill && lat_wen && win == IW'(i)) begin
                    wdone[i]      <= 1'b1;
                    wdone_addr[i] <= lat_addr;
                end else if (!slot_cs[i] || !slot_wen[i] || slot_addr[i*AW +: AW] != wdone_addr[i]) begin
                    wdone[i]      <= 1'b0;
                end
            end
        end
    end

`ifdef JTCOP_SDRAM_ARB_STARVE_EN
    localparam int CW = $clog2(MAXWAIT + 1);
    logic [CW-1:0] wait_cnt [SLOTS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                // The slot already in flight is being served, so it does not accumulate wait time.
                if (!pending[i] || (grant && gnt_oh[i]) || (state != IDLE && win == IW'(i))) begin
                    wait_cnt[i] <= '0;
                end else if (wait_cnt[i] != CW'(MAXWAIT)) begin
                    wait_cnt[i] <= wait_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < SLOTS; i++) starve[i] = wait_cnt[i] == CW'(MAXWAIT);
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, sdram.data_dst};
`else
    assign starve = '0;

    logic unused_ok;
    assign unused_ok = &{1'b0, sdram.data_dst, gnt_oh, grant, MAXWAIT[0]};
`endif

endmodule
